id_operand_fetch: RTL and testbench
===================================

# id_operand_fetch

Decode/operand-fetch stage. Reads source operands for the instruction in ID from the general registers gr0–gr7 that the writeback stage drives. Resolves RAW hazards by forwarding from EX, MEM and WB, and stalls one cycle on a load-use hazard. Registers the EX-stage operands (ex_ir, reg_A, reg_B, smdr) for the ALU and memory stages.

## Interface
Parameters: none. Opcode, register-select and NOP encodings come from define.v.

- clock  in  1  stage clock, rising edge
- reset  in  1  reset, asynchronous, active-low
- state  in  1  CPU run state; the stage advances only when equal to `exec
- flush  in  1  branch-taken kill; overrides all other controls
- id_ir  in  16  instruction in ID
- gr0..gr7  in  16 each  architectural registers, as driven by writeback
- ALUo  in  16  combinational ALU result of the instruction in EX
- mem_ir  in  16  instruction in MEM
- mem_result  in  16  value MEM will write back (load data or ALU result)
- wb_ir  in  16  instruction in WB
- reg_C1  in  16  value WB is writing this cycle
- ex_ir  out  16  registered instruction for EX
- reg_A  out  16  registered operand A
- reg_B  out  16  registered operand B
- smdr  out  16  registered store data
- stall  out  1  combinational; holds IF/ID when 1

## Operation
- **Writer set W:** LOAD, LDIH, ADD, ADDI, ADDC, SUB, SUBI, SUBC, AND, OR, XOR, SLL, SRL, SLA, SRA. The destination is ir[10:8].
- **Field use by id_ir opcode:**
  - ADD/ADDC/SUB/SUBC/AND/OR/XOR/CMP: A = R[ir[6:4]], B = R[ir[2:0]].
  - ADDI/SUBI: A = R[ir[10:8]], B = {8'h00, ir[7:0]}.
  - LDIH: A = R[ir[10:8]], B = {ir[7:0], 8'h00}.
  - SLL/SRL/SLA/SRA/LOAD: A = R[ir[6:4]], B = {12'h000, ir[3:0]}.
  - STORE: A = R[ir[6:4]], B = {12'h000, ir[3:0]}, smdr = R[ir[10:8]].
  - Any other opcode: A = B = 0.
  - smdr is 0 for every non-STORE opcode.
- **Operand value R[n] priority, first match wins:**
  1. ex_ir in W, ex_ir is not LOAD, and ex_ir[10:8]==n: use ALUo.
  2. mem_ir in W and mem_ir[10:8]==n: use mem_result.
  3. wb_ir in W and wb_ir[10:8]==n: use reg_C1. This covers the same-edge register-file write.
  4. Otherwise use gr[n].
- **Load-use hazard:** ex_ir is LOAD and ex_ir[10:8] equals any source register that id_ir actually uses (per the field table).
  - stall = hazard & (state==`exec) & ~flush.
- **Register update at rising clock:**
  - reset low (async): ex_ir, reg_A, reg_B, smdr = 16'h0000 (the NOP encoding).
  - state != `exec: all outputs hold.
  - flush: ex_ir = NOP, and reg_A, reg_B, smdr = 0.
  - else stall: insert a bubble with the same values as flush. The ID instruction is retained upstream.
  - else: load ex_ir = id_ir and the computed A, B, smdr.
- Arithmetic is 16-bit, with no sign extension of immediates.
- Unused source fields never trigger a hazard. Example: the ir[2:0] bits of ADDI are not a source.

## Timing
- One-cycle latency: operands sampled in cycle n appear on the outputs after edge n+1.
- A load-use hazard costs exactly one bubble. In the next cycle the LOAD is in MEM and the operand is forwarded from mem_result, so stall deasserts.
- stall is combinational from id_ir and ex_ir, with no registered delay.
- If flush and stall are asserted together, flush wins and stall reads 0.
- Reset mid-operation clears all outputs immediately, regardless of clock. The first edge after reset release with state==`exec loads id_ir normally.
- gr0..gr7 may change on the same edge the outputs load. WB forwarding guarantees the pre-edge write value is captured.

## Test plan
- **Basic ALU read:** gr2=0x1234, gr3=0x0011, no pipeline writers; id_ir=ADD gr1,gr2,gr3 -> after one edge ex_ir=id_ir, reg_A=0x1234, reg_B=0x0011, smdr=0, stall=0.
- **Forwarding priority:** ex_ir=ADDI gr2 with ALUo=0xAAAA, mem_ir=ADD gr2 with mem_result=0xBBBB, wb_ir=SUB gr2 with reg_C1=0xCCCC, gr2=0xDDDD -> reg_A=0xAAAA. Remove ex -> 0xBBBB. Remove mem -> 0xCCCC. Remove wb -> 0xDDDD.
- **Load-use:** ex_ir=LOAD gr4; id_ir=ADD gr1,gr4,gr0 -> stall=1, next edge ex_ir=0x0000 and A=B=0. Following cycle: mem_ir=LOAD gr4, mem_result=0x5A5A -> stall=0, reg_A=0x5A5A.
- **Immediates/store:**
  - LDIH gr1,0x7F -> reg_B=0x7F00.
  - STORE gr5,gr6,0x3 with gr5=0x0102, gr6=0x0200 -> reg_A=0x0200, reg_B=0x0003, smdr=0x0102.
  - ADDI gr1 with ex_ir=LOAD gr0 -> no stall, since ir[2:0] is not a source.
- **Control:**
  - flush with a hazard present -> stall=0, ex_ir=NOP.
  - state != `exec -> outputs hold for 3 cycles.
  - reset pulse mid-stream -> all outputs 0 without a clock edge.

Source files
------------

// File: rtl/id_operand_fetch.sv
// Decode/operand-fetch stage: selects source operands with EX/MEM/WB forwarding,
// detects load-use hazards and registers the EX-stage instruction and operands.
module id_operand_fetch (
  input  logic        clock,
  input  logic        reset,
  input  logic        state,
  input  logic        flush,
  input  logic [15:0] id_ir,
  input  logic [15:0] gr0,
  input  logic [15:0] gr1,
  input  logic [15:0] gr2,
  input  logic [15:0] gr3,
  input  logic [15:0] gr4,
  input  logic [15:0] gr5,
  input  logic [15:0] gr6,
  input  logic [15:0] gr7,
  input  logic [15:0] ALUo,
  input  logic [15:0] mem_ir,
  input  logic [15:0] mem_result,
  input  logic [15:0] wb_ir,
  input  logic [15:0] reg_C1,
  output logic [15:0] ex_ir,
  output logic [15:0] reg_A,
  output logic [15:0] reg_B,
  output logic [15:0] smdr,
  output logic        stall
);

  localparam logic        EXEC     = 1'b1;
  localparam logic [15:0] NOP_IR   = 16'h0000;

  localparam logic [4:0] OP_LOAD  = 5'b00010;
  localparam logic [4:0] OP_STORE = 5'b00011;
  localparam logic [4:0] OP_SLL   = 5'b00100;
  localparam logic [4:0] OP_SLA   = 5'b00101;
  localparam logic [4:0] OP_SRL   = 5'b00110;
  localparam logic [4:0] OP_SRA   = 5'b00111;
  localparam logic [4:0] OP_ADD   = 5'b01000;
  localparam logic [4:0] OP_ADDI  = 5'b01001;
  localparam logic [4:0] OP_SUB   = 5'b01010;
  localparam logic [4:0] OP_SUBI  = 5'b01011;
  localparam logic [4:0] OP_CMP   = 5'b01100;
  localparam logic [4:0] OP_AND   = 5'b01101;
  localparam logic [4:0] OP_OR    = 5'b01110;
  localparam logic [4:0] OP_XOR   = 5'b01111;
  localparam logic [4:0] OP_LDIH  = 5'b10000;
  localparam logic [4:0] OP_ADDC  = 5'b10001;
  localparam logic [4:0] OP_SUBC  = 5'b10010;

  function automatic logic is_writer(input logic [4:0] op);
    case (op)
      OP_LOAD, OP_LDIH, OP_ADD, OP_ADDI, OP_ADDC, OP_SUB, OP_SUBI, OP_SUBC,
      OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SLA, OP_SRA: is_writer = 1'b1;
      default: is_writer = 1'b0;
    endcase
  endfunction

  logic [15:0] ex_ir_q, reg_a_q, reg_b_q, smdr_q;
  logic [15:0] ex_ir_d, reg_a_d, reg_b_d, smdr_d;

  logic [4:0]  id_op, ex_op, mem_op, wb_op;
  logic [2:0]  ex_dst, mem_dst, wb_dst;
  logic        ex_fwd, mem_fwd, wb_fwd;
  logic [15:0] gr_w [8];
  logic [15:0] opnd [8];

  assign id_op   = id_ir[15:11];
  assign ex_op   = ex_ir_q[15:11];
  assign mem_op  = mem_ir[15:11];
  assign wb_op   = wb_ir[15:11];
  assign ex_dst  = ex_ir_q[10:8];
  assign mem_dst = mem_ir[10:8];
  assign wb_dst  = wb_ir[10:8];

  // A LOAD in EX has no data yet; ALUo would be its address, so it is never forwarded.
  assign ex_fwd  = is_writer(ex_op) && (ex_op != OP_LOAD);
  assign mem_fwd = is_writer(mem_op);
  assign wb_fwd  = is_writer(wb_op);

  assign gr_w[0] = gr0;
  assign gr_w[1] = gr1;
  assign gr_w[2] = gr2;
  assign gr_w[3] = gr3;
  assign gr_w[4] = gr4;
  assign gr_w[5] = gr5;
  assign gr_w[6] = gr6;
  assign gr_w[7] = gr7;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_fwd
      assign opnd[gi] = (ex_fwd  && ex_dst  == 3'(gi)) ? ALUo       :
                        (mem_fwd && mem_dst == 3'(gi)) ? mem_result :
                        (wb_fwd  && wb_dst  == 3'(gi)) ? reg_C1     :
                                                         gr_w[gi];
    end
  endgenerate

  logic        use_a, use_b, use_s;
  logic [2:0]  a_sel;
  logic [15:0] a_val, b_val, s_val;

  always_comb begin
    use_a = 1'b0;
    use_b = 1'b0;
    use_s = 1'b0;
    a_sel = id_ir[6:4];
    b_val = 16'h0000;
    case (id_op)
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_AND, OP_OR, OP_XOR, OP_CMP: begin
        use_a = 1'b1;
        use_b = 1'b1;
        b_val = opnd[id_ir[2:0]];
      end
      OP_ADDI, OP_SUBI: begin
        use_a = 1'b1;
        a_sel = id_ir[10:8];
        b_val = {8'h00, id_ir[7:0]};
      end
      OP_LDIH: begin
        use_a = 1'b1;
        a_sel = id_ir[10:8];
        b_val = {id_ir[7:0], 8'h00};
      end
      OP_SLL, OP_SRL, OP_SLA, OP_SRA, OP_LOAD: begin
        use_a = 1'b1;
        b_val = {12'h000, id_ir[3:0]};
      end
      OP_STORE: begin
        use_a = 1'b1;
        use_s = 1'b1;
        b_val = {12'h000, id_ir[3:0]};
      end
      default: ;
    endcase
  end

  assign a_val = use_a ? opnd[a_sel] : 16'h0000;
  assign s_val = use_s ? opnd[id_ir[10:8]] : 16'h0000;

  // Only fields the opcode really reads may match the pending load destination.
  logic hazard;
  assign hazard = (ex_op == OP_LOAD) &&
                  ((use_a && ex_dst == a_sel) ||
                   (use_b && ex_dst == id_ir[2:0]) ||
                   (use_s && ex_dst == id_ir[10:8]));

  assign stall = hazard && (state == EXEC) && !flush;

  always_comb begin
    ex_ir_d = NOP_IR;
    reg_a_d = 16'h0000;
    reg_b_d = 16'h0000;
    smdr_d  = 16'h0000;
    if (!flush && !hazard) begin
      ex_ir_d = id_ir;
      reg_a_d = a_val;
      reg_b_d = b_val;
      smdr_d  = s_val;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_ir_q <= NOP_IR;
      reg_a_q <= 16'h0000;
      reg_b_q <= 16'h0000;
      smdr_q  <= 16'h0000;
    end else if (state == EXEC) begin
      ex_ir_q <= ex_ir_d;
      reg_a_q <= reg_a_d;
      reg_b_q <= reg_b_d;
      smdr_q  <= smdr_d;
    end
  end

  assign ex_ir = ex_ir_q;
  assign reg_A = reg_a_q;
  assign reg_B = reg_b_q;
  assign smdr  = smdr_q;

  logic unused_bits;
  assign unused_bits = ^{mem_ir[7:0], wb_ir[7:0]};

endmodule

// File: tb/tb_id_operand_fetch.sv
// Directed bench for id_operand_fetch: stimulus pushes expectations into queues,
// separate monitors pop and compare stall (mid-cycle) and registered outputs (after the edge).
module tb_id_operand_fetch;

  logic        clock = 1'b0;
  logic        reset, state, flush;
  logic [15:0] id_ir, ALUo, mem_ir, mem_result, wb_ir, reg_C1;
  logic [15:0] gr [8];
  logic [15:0] ex_ir, reg_A, reg_B, smdr;
  logic        stall;

  id_operand_fetch dut (
    .clock(clock), .reset(reset), .state(state), .flush(flush), .id_ir(id_ir),
    .gr0(gr[0]), .gr1(gr[1]), .gr2(gr[2]), .gr3(gr[3]),
    .gr4(gr[4]), .gr5(gr[5]), .gr6(gr[6]), .gr7(gr[7]),
    .ALUo(ALUo), .mem_ir(mem_ir), .mem_result(mem_result),
    .wb_ir(wb_ir), .reg_C1(reg_C1),
    .ex_ir(ex_ir), .reg_A(reg_A), .reg_B(reg_B), .smdr(smdr), .stall(stall)
  );

  always #5 clock = ~clock;

  typedef struct { string name; logic [15:0] ex, a, b, s; } out_t;
  typedef struct { string name; logic st; } stl_t;

  out_t out_q[$];
  stl_t stl_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin : stall_monitor
    stl_t e;
    forever begin
      @(negedge clock);
      if (stl_q.size() > 0) begin
        e = stl_q.pop_front();
        chk({e.name, "/stall"}, {15'b0, stall}, {15'b0, e.st});
      end
    end
  end

  initial begin : out_monitor
    out_t e;
    forever begin
      @(posedge clock);
      #1;
      if (out_q.size() > 0) begin
        e = out_q.pop_front();
        chk({e.name, "/ex_ir"}, ex_ir, e.ex);
        chk({e.name, "/reg_A"}, reg_A, e.a);
        chk({e.name, "/reg_B"}, reg_B, e.b);
        chk({e.name, "/smdr"},  smdr,  e.s);
      end
    end
  end

  task automatic quiet();
    state = 1'b1; flush = 1'b0; ALUo = 16'h0; mem_ir = 16'h0;
    mem_result = 16'h0; wb_ir = 16'h0; reg_C1 = 16'h0;
  endtask

  task automatic step(input string name, input logic [15:0] ir, input logic st,
                      input logic [15:0] ex, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] s);
    id_ir = ir;
    stl_q.push_back('{name: name, st: st});
    out_q.push_back('{name: name, ex: ex, a: a, b: b, s: s});
    $display("txn %s: id_ir=%h state=%0b flush=%0b exp stall=%0b ex_ir=%h A=%h B=%h smdr=%h",
             name, ir, state, flush, st, ex, a, b, s);
    @(posedge clock);
    #2;
  endtask

  initial begin
    reset = 1'b0;
    id_ir = 16'h0;
    for (int i = 0; i < 8; i++) gr[i] = 16'h0;
    quiet();
    #3;
    chk("reset/ex_ir", ex_ir, 16'h0);
    chk("reset/reg_A", reg_A, 16'h0);
    chk("reset/reg_B", reg_B, 16'h0);
    chk("reset/smdr",  smdr,  16'h0);
    @(posedge clock);
    #2;
    reset = 1'b1;

    // Basic ALU read
    gr[2] = 16'h1234; gr[3] = 16'h0011;
    step("basic_add", 16'h4123, 0, 16'h4123, 16'h1234, 16'h0011, 16'h0000);

    // Forwarding priority on r2: EX > MEM > WB > register file
    gr[2] = 16'hDDDD;
    step("load_addi_r2", 16'h4A05, 0, 16'h4A05, 16'hDDDD, 16'h0005, 16'h0000);
    ALUo = 16'hAAAA; mem_ir = 16'h4200; mem_result = 16'hBBBB;
    wb_ir = 16'h5200; reg_C1 = 16'hCCCC;
    step("fwd_ex", 16'h4123, 0, 16'h4123, 16'hAAAA, 16'h0011, 16'h0000);
    step("fwd_mem", 16'h4123, 0, 16'h4123, 16'hBBBB, 16'h0011, 16'h0000);
    mem_ir = 16'h0000;
    step("fwd_wb", 16'h4123, 0, 16'h4123, 16'hCCCC, 16'h0011, 16'h0000);
    wb_ir = 16'h6200;
    step("cmp_no_fwd", 16'h4123, 0, 16'h4123, 16'hDDDD, 16'h0011, 16'h0000);
    quiet(); ALUo = 16'h7777;
    step("fwd_ex_on_b", 16'h4131, 0, 16'h4131, 16'h0011, 16'h7777, 16'h0000);

    // Load-use hazards on A, B and store-data fields
    quiet();
    step("load_r4", 16'h1400, 0, 16'h1400, 16'h0000, 16'h0000, 16'h0000);
    step("use_a_stall", 16'h4140, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    mem_ir = 16'h1400; mem_result = 16'h5A5A;
    step("use_a_mem_fwd", 16'h4140, 0, 16'h4140, 16'h5A5A, 16'h0000, 16'h0000);
    quiet();
    step("load_r4_b", 16'h1400, 0, 16'h1400, 16'h0000, 16'h0000, 16'h0000);
    step("use_b_stall", 16'h4104, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    step("load_r4_s", 16'h1400, 0, 16'h1400, 16'h0000, 16'h0000, 16'h0000);
    step("use_smdr_stall", 16'h1C01, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    step("load_r1", 16'h1100, 0, 16'h1100, 16'h0000, 16'h0000, 16'h0000);
    step("addi_dst_stall", 16'h4900, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    step("load_r0", 16'h1000, 0, 16'h1000, 16'h0000, 16'h0000, 16'h0000);
    gr[1] = 16'h0009;
    step("addi_imm_no_stall", 16'h4900, 0, 16'h4900, 16'h0009, 16'h0000, 16'h0000);

    // Immediates, store, shift, unknown opcode
    ALUo = 16'h1111;
    step("ldih", 16'h817F, 0, 16'h817F, 16'h1111, 16'h7F00, 16'h0000);
    quiet(); gr[5] = 16'h0102; gr[6] = 16'h0200;
    step("store", 16'h1D63, 0, 16'h1D63, 16'h0200, 16'h0003, 16'h0102);
    step("sll", 16'h2125, 0, 16'h2125, 16'hDDDD, 16'h0005, 16'h0000);
    step("other_op", 16'hC0FF, 0, 16'hC0FF, 16'h0000, 16'h0000, 16'h0000);

    // Flush overrides a present hazard
    step("load_r4_f", 16'h1400, 0, 16'h1400, 16'h0000, 16'h0000, 16'h0000);
    flush = 1'b1;
    step("flush_hazard", 16'h4140, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    quiet();

    // Hold while not executing, even with a hazard present
    step("load_r4_r2", 16'h1427, 0, 16'h1427, 16'hDDDD, 16'h0007, 16'h0000);
    state = 1'b0;
    for (int i = 0; i < 3; i++) begin
      gr[2] = 16'h0F0F + 16'(i);
      step($sformatf("hold%0d", i), 16'h4140 + 16'(i), 0, 16'h1427, 16'hDDDD, 16'h0007, 16'h0000);
    end
    quiet(); gr[2] = 16'hDDDD;
    step("after_hold_stall", 16'h4140, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    gr[2] = 16'h1234;
    step("reload", 16'h4123, 0, 16'h4123, 16'h1234, 16'h0011, 16'h0000);

    // Asynchronous reset mid-cycle, then normal load
    #2;
    reset = 1'b0;
    #1;
    chk("midreset/ex_ir", ex_ir, 16'h0);
    chk("midreset/reg_A", reg_A, 16'h0);
    chk("midreset/reg_B", reg_B, 16'h0);
    chk("midreset/smdr",  smdr,  16'h0);
    @(posedge clock);
    #2;
    reset = 1'b1;
    step("post_reset", 16'h4131, 0, 16'h4131, 16'h0011, 16'h0009, 16'h0000);

    repeat (2) @(posedge clock);
    #2;
    n_checks++;
    if (out_q.size() != 0 || stl_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending %0d expected 0", out_q.size() + stl_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
